// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      WAIT_RESP = 2'd1,
      DROP      = 2'd2
   } fetch_state_e;

   localparam int unsigned FETCH_ADDR_LEN = 32;

   localparam logic [FETCH_ADDR_LEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

   // Buffered instruction: fetch address alongside the returned word.
   typedef struct packed {
      logic [FETCH_ADDR_LEN-1:0] pc;
      logic [31:0]               inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through instruction buffer with flush.
// The head entry is presented combinationally whenever the buffer is not empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic   clk,
   input  logic   rstn,
   input  logic   flush,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output logic   valid,
   output logic   full,
   output entry_t head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign valid   = (count != '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & valid & ~flush;
   assign head    = mem[rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Instruction fetch controller: one outstanding icache request, FWFT buffer to decode.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt_o / drop_cnt_o performance counters.
module icache_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned          ADDR_LEN   = 32,
   parameter int unsigned          FIFO_DEPTH = 4,
   parameter logic [ADDR_LEN-1:0]  RESET_PC   = ADDR_LEN'(DEFAULT_RESET_PC)
) (
   input  logic                clk,
   input  logic                rstn,

   input  logic                redirect_valid_i,
   input  logic [ADDR_LEN-1:0] redirect_pc_i,

   output logic                req_valid_o,
   input  logic                req_ready_i,
   output logic [ADDR_LEN-1:0] req_addr_o,

   input  logic                resp_valid_i,
   output logic                resp_ready_o,
   input  logic [31:0]         resp_data_i,
   input  logic [ADDR_LEN-1:0] resp_addr_i,

   output logic                inst_valid_o,
   input  logic                inst_ready_i,
   output logic [31:0]         inst_o,
   output logic [ADDR_LEN-1:0] inst_pc_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         fetch_cnt_o,
   output logic [31:0]         drop_cnt_o
`endif
);

   typedef struct packed {
      logic [ADDR_LEN-1:0] pc;
      logic [31:0]         inst;
   } entry_t;

   fetch_state_e        state_q;
   fetch_state_e        state_d;
   logic [ADDR_LEN-1:0] pc_q;
   logic [ADDR_LEN-1:0] pc_d;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_valid;
   entry_t              fifo_head;
   entry_t              fifo_wdata;
   logic                resp_fire;

   assign req_addr_o = pc_q;
   assign resp_fire  = resp_valid_i & resp_ready_o;
   assign fifo_pop   = fifo_valid & inst_ready_i;
   assign fifo_wdata = '{pc: resp_addr_i, inst: resp_data_i};

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_valid_o  = 1'b0;
      resp_ready_o = 1'b0;
      fifo_push    = 1'b0;

      case (state_q)
         FETCH: begin
            // The buffer slot is effectively reserved here, so a response never finds it full.
            req_valid_o = ~fifo_full & ~redirect_valid_i;
            if (req_valid_o && req_ready_i) begin
               pc_d    = pc_q + ADDR_LEN'(4);
               state_d = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            resp_ready_o = 1'b1;
            if (redirect_valid_i) begin
               state_d = resp_valid_i ? FETCH : DROP;
            end else if (resp_valid_i) begin
               fifo_push = 1'b1;
               state_d   = FETCH;
            end
         end
         DROP: begin
            resp_ready_o = 1'b1;
            if (resp_valid_i) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase

      if (redirect_valid_i) pc_d = redirect_pc_i & ~ADDR_LEN'(3);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (redirect_valid_i),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .valid     (fifo_valid),
      .full      (fifo_full),
      .head      (fifo_head)
   );

   assign inst_valid_o = fifo_valid;
   assign inst_o       = fifo_head.inst;
   assign inst_pc_o    = fifo_head.pc;

`ifdef FETCH_PERF_CNT_EN
   // A response is discarded when it lands in DROP or together with a redirect.
   logic drop_evt;
   assign drop_evt = resp_fire & ((state_q == DROP) | redirect_valid_i);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         fetch_cnt_o <= '0;
         drop_cnt_o  <= '0;
      end else begin
         if (fifo_push) fetch_cnt_o <= fetch_cnt_o + 32'd1;
         if (drop_evt)  drop_cnt_o  <= drop_cnt_o + 32'd1;
      end
   end
`else
   // Counters are not built; response handling is otherwise unchanged.
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Bench for icache_fetch_ctrl: directed steps then randomized traffic against a queue model.
// Perf counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_icache_fetch_ctrl;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rstn;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        req_valid_o;
   logic        req_ready_i;
   logic [31:0] req_addr_o;
   logic        resp_valid_i;
   logic        resp_ready_o;
   logic [31:0] resp_data_i;
   logic [31:0] resp_addr_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] drop_cnt_o;
`endif

   always #5 clk = ~clk;

   icache_fetch_ctrl #(
      .ADDR_LEN   (32),
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .req_valid_o      (req_valid_o),
      .req_ready_i      (req_ready_i),
      .req_addr_o       (req_addr_o),
      .resp_valid_i     (resp_valid_i),
      .resp_ready_o     (resp_ready_o),
      .resp_data_i      (resp_data_i),
      .resp_addr_i      (resp_addr_i),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
      .inst_o           (inst_o),
      .inst_pc_o        (inst_pc_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt_o      (fetch_cnt_o),
      .drop_cnt_o       (drop_cnt_o)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference model: next fetch PC, expected decode queue, one outstanding request.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   bit          m_busy;
   bit          m_stale;
   int unsigned m_fetch;
   int unsigned m_drop;
   logic [31:0] last_req;

   // Simple icache responder used by the randomized phase.
   bit          pend_valid;
   logic [31:0] pend_addr;
   int          pend_wait;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pc       = RST_PC;
      m_busy     = 0;
      m_stale    = 0;
      m_fetch    = 0;
      m_drop     = 0;
      pend_valid = 0;
      pend_wait  = 0;
   endtask

   task automatic idle();
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
      req_ready_i      = 1'b0;
      resp_valid_i     = 1'b0;
      resp_data_i      = '0;
      resp_addr_i      = '0;
      inst_ready_i     = 1'b0;
   endtask

   // Compare outputs to the model with current inputs, advance the model, cross one edge.
   task automatic run_cycle();
      bit exp_rv, fire_req, fire_resp, pop;
      exp_rv = !m_busy && (m_q.size() < DEPTH) && !redirect_valid_i;
      check("req_valid", {31'd0, req_valid_o}, {31'd0, exp_rv});
      check("req_addr", req_addr_o, m_pc);
      check("resp_ready", {31'd0, resp_ready_o}, {31'd0, m_busy});
      check("inst_valid", {31'd0, inst_valid_o}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) begin
         check("inst", inst_o, m_q[0].inst);
         check("inst_pc", inst_pc_o, m_q[0].pc);
      end
`ifdef FETCH_PERF_CNT_EN
      check("fetch_cnt", fetch_cnt_o, m_fetch);
      check("drop_cnt", drop_cnt_o, m_drop);
`endif
      fire_req  = exp_rv && req_ready_i;
      fire_resp = m_busy && resp_valid_i;
      pop       = (m_q.size() != 0) && inst_ready_i;

      if (redirect_valid_i) begin
         m_q.delete();
         m_pc = {redirect_pc_i[31:2], 2'b00};
         if (fire_resp) begin
            m_busy  = 0;
            m_stale = 0;
            m_drop++;
         end else if (m_busy) begin
            m_stale = 1;
         end
      end else begin
         if (pop) void'(m_q.pop_front());
         if (fire_resp) begin
            if (m_stale) m_drop++;
            else begin
               m_q.push_back('{pc: resp_addr_i, inst: resp_data_i});
               m_fetch++;
            end
            m_busy  = 0;
            m_stale = 0;
         end
      end

      if (fire_resp) pend_valid = 0;
      else if (pend_valid && pend_wait > 0) pend_wait--;
      if (fire_req) begin
         last_req   = m_pc;
         m_pc       = m_pc + 32'd4;
         m_busy     = 1;
         m_stale    = 0;
         pend_valid = 1;
         pend_addr  = last_req;
         pend_wait  = $urandom_range(0, 2);
      end
      @(posedge clk);
      #1;
   endtask

   // Request handshake then response on the following cycle.
   task automatic fetch_resp(input logic [31:0] data);
      req_ready_i = 1'b1;
      #1; run_cycle();
      req_ready_i  = 1'b0;
      resp_valid_i = 1'b1;
      resp_addr_i  = last_req;
      resp_data_i  = data;
      #1; run_cycle();
      resp_valid_i = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      model_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      #1;
      check("rst_req_valid", {31'd0, req_valid_o}, 32'd1);
      check("rst_req_addr", req_addr_o, 32'h8000_0000);
      check("rst_resp_ready", {31'd0, resp_ready_o}, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);

      // First fetch, response two cycles after issue.
      req_ready_i = 1'b1;
      #1; run_cycle();
      req_ready_i = 1'b0;
      #1;
      check("first_next_addr", req_addr_o, 32'h8000_0004);
      run_cycle();
      resp_valid_i = 1'b1;
      resp_addr_i  = 32'h8000_0000;
      resp_data_i  = 32'h0000_0013;
      #1; run_cycle();
      resp_valid_i = 1'b0;
      #1;
      check("first_inst", inst_o, 32'h0000_0013);
      check("first_inst_pc", inst_pc_o, 32'h8000_0000);
      check("first_req_addr2", req_addr_o, 32'h8000_0004);
      inst_ready_i = 1'b1;
      #1; run_cycle();
      inst_ready_i = 1'b0;

      // Fill the buffer with decode stalled; fifth and sixth attempts must not issue.
      for (int i = 0; i < 4; i++) fetch_resp(32'h0000_1000 + i);
      req_ready_i = 1'b1;
      #1;
      check("full_req_valid", {31'd0, req_valid_o}, 32'd0);
      check("full_head_pc", inst_pc_o, 32'h8000_0004);
      run_cycle();
      #1; run_cycle();
      inst_ready_i = 1'b1;
      #1; run_cycle();
      inst_ready_i = 1'b0;
      #1;
      check("after_pop_req_valid", {31'd0, req_valid_o}, 32'd1);
      check("after_pop_req_addr", req_addr_o, 32'h8000_0014);
      run_cycle();
      req_ready_i  = 1'b0;
      resp_valid_i = 1'b1;
      resp_addr_i  = last_req;
      resp_data_i  = 32'h0000_2000;
      #1; run_cycle();
      resp_valid_i = 1'b0;
      req_ready_i  = 1'b1;
      #1;
      check("refull_req_valid", {31'd0, req_valid_o}, 32'd0);
      run_cycle();
      req_ready_i = 1'b0;

      // Drain to two entries, then push and pop together across the pointer wrap.
      inst_ready_i = 1'b1;
      #1; run_cycle();
      #1; run_cycle();
      inst_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req_ready_i = 1'b1;
         #1; run_cycle();
         req_ready_i  = 1'b0;
         resp_valid_i = 1'b1;
         resp_addr_i  = last_req;
         resp_data_i  = 32'h0000_3000 + k;
         inst_ready_i = 1'b1;
         #1; run_cycle();
         resp_valid_i = 1'b0;
         inst_ready_i = 1'b0;
      end
      #1;
      check("wrap_head_pc", inst_pc_o, 32'h8000_001C);
      inst_ready_i = 1'b1;
      run_cycle();
      #1;
      check("wrap_second_pc", inst_pc_o, 32'h8000_0020);
      check("wrap_second_inst", inst_o, 32'h0000_3002);
      run_cycle();
      inst_ready_i = 1'b0;
      #1;
      check("wrap_drained", {31'd0, inst_valid_o}, 32'd0);

      // Redirect while a response is pending: flush, drop the stale response.
      fetch_resp(32'h0000_4000);
      req_ready_i = 1'b1;
      #1; run_cycle();
      req_ready_i      = 1'b0;
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0102;
      #1;
      check("redir_wait_req_valid", {31'd0, req_valid_o}, 32'd0);
      run_cycle();
      redirect_valid_i = 1'b0;
      #1;
      check("drop_fifo_empty", {31'd0, inst_valid_o}, 32'd0);
      check("drop_resp_ready", {31'd0, resp_ready_o}, 32'd1);
      check("drop_req_valid", {31'd0, req_valid_o}, 32'd0);
      run_cycle();
      resp_valid_i = 1'b1;
      resp_addr_i  = 32'h8000_0028;
      resp_data_i  = 32'hDEAD_BEEF;
      #1; run_cycle();
      resp_valid_i = 1'b0;
      #1;
      check("stale_not_pushed", {31'd0, inst_valid_o}, 32'd0);
      check("redir_req_valid", {31'd0, req_valid_o}, 32'd1);
      check("redir_req_addr", req_addr_o, 32'h8000_0100);
`ifdef FETCH_PERF_CNT_EN
      check("perf_drop_cnt", drop_cnt_o, 32'd1);
      check("perf_fetch_cnt", fetch_cnt_o, 32'd10);
`endif

      // Redirect in the same cycle as the response.
      req_ready_i = 1'b1;
      #1; run_cycle();
      req_ready_i      = 1'b0;
      resp_valid_i     = 1'b1;
      resp_addr_i      = 32'h8000_0100;
      resp_data_i      = 32'h0000_0055;
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0200;
      #1; run_cycle();
      resp_valid_i     = 1'b0;
      redirect_valid_i = 1'b0;
      #1;
      check("redir_resp_no_push", {31'd0, inst_valid_o}, 32'd0);
      check("redir_resp_fetch", {31'd0, req_valid_o}, 32'd1);
      check("redir_resp_addr", req_addr_o, 32'h8000_0200);
      check("redir_resp_ready", {31'd0, resp_ready_o}, 32'd0);

      // Redirect in FETCH together with a pop: no request, buffer empties.
      fetch_resp(32'h0000_0066);
      inst_ready_i     = 1'b1;
      req_ready_i      = 1'b1;
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0303;
      #1;
      check("redir_fetch_req_valid", {31'd0, req_valid_o}, 32'd0);
      run_cycle();
      redirect_valid_i = 1'b0;
      inst_ready_i     = 1'b0;
      #1;
      check("redir_pop_empty", {31'd0, inst_valid_o}, 32'd0);
      check("redir_fetch_addr", req_addr_o, 32'h8000_0300);
      run_cycle();
      req_ready_i = 1'b0;

      // Reset with a request outstanding; the late response must be refused.
      rstn = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      rstn         = 1'b1;
      resp_valid_i = 1'b1;
      resp_addr_i  = 32'h8000_0300;
      resp_data_i  = 32'h0000_0077;
      #1;
      check("post_rst_resp_ready", {31'd0, resp_ready_o}, 32'd0);
      check("post_rst_req_addr", req_addr_o, RST_PC);
      run_cycle();
      resp_valid_i = 1'b0;
      #1;
      check("post_rst_no_push", {31'd0, inst_valid_o}, 32'd0);

      // Randomized traffic against the model.
      for (int cyc = 0; cyc < 800; cyc++) begin
         logic [31:0] rp;
         rp               = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
         req_ready_i      = ($urandom_range(0, 9) < 7);
         inst_ready_i     = $urandom_range(0, 1);
         redirect_valid_i = ($urandom_range(0, 19) == 0);
         redirect_pc_i    = rp;
         if (pend_valid && pend_wait == 0) begin
            resp_valid_i = 1'b1;
            resp_addr_i  = pend_addr;
            resp_data_i  = mem_word(pend_addr);
         end else if (!m_busy && $urandom_range(0, 9) == 0) begin
            resp_valid_i = 1'b1;
            resp_addr_i  = $urandom;
            resp_data_i  = $urandom;
         end else begin
            resp_valid_i = 1'b0;
         end
         #1; run_cycle();
      end

      // Drain: let any outstanding response land, then empty the buffer.
      for (int cyc = 0; cyc < 12; cyc++) begin
         idle();
         inst_ready_i = 1'b1;
         if (pend_valid && pend_wait == 0) begin
            resp_valid_i = 1'b1;
            resp_addr_i  = pend_addr;
            resp_data_i  = mem_word(pend_addr);
         end
         #1; run_cycle();
      end
      idle();
      #1;
      check("final_empty", {31'd0, inst_valid_o}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
